aq_biu_apbarb: RTL

//  Round-robin arbiter that shares the single BIU APB bridge (aq_biu_apbif) among NM AXI-lite style requesters.

---
 rtl/aq_biu_apbarb_pkg.sv | 23 ++
 rtl/aq_biu_rr_arb.sv | 37 +++
 rtl/aq_biu_apbarb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/aq_biu_apbarb_pkg.sv
// Shared definitions for the BIU APB-bridge arbiter: FSM encoding, field
// widths and response codes.
package aq_biu_apbarb_pkg;

  localparam int NM_MAX = 4;
  localparam int IDW    = 4;
  localparam int PROTW  = 2;
  localparam int DATAW  = 128;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Two state bits for the address/data phases plus one for response phases.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_AW   = 3'd2,
    ST_WD   = 3'd3,
    ST_RD   = 3'd4,
    ST_WB   = 3'd5,
    ST_BR   = 3'd6
  } arb_state_e;

endpackage

// File: rtl/aq_biu_rr_arb.sv
// Round-robin pick: the first set request at or after ptr, wrapping modulo NM.
module aq_biu_rr_arb #(
  parameter int NM = 2,
  parameter int IW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_any,
  output logic [IW-1:0] gnt_idx,
  output logic [NM-1:0] gnt_oh
);

  int          cand_i;
  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    cand_i  = 0;
    cand    = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      cand_i = int'(ptr) + k;
      if (cand_i >= NM) cand_i = cand_i - NM;
      cand = IW'(cand_i);
      if (req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_oh[gnt_idx] = gnt_any;
  end

endmodule

// File: rtl/aq_biu_apbarb.sv
// Shares the single BIU APB bridge among NM AXI-lite style requesters.
// One owner at a time, held until its transaction fully completes; the write
// response is generated here because the bridge does not return one.
module aq_biu_apbarb
  import aq_biu_apbarb_pkg::*;
#(
  parameter int NM    = 2,
  parameter int ADDRW = 40
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic [NM-1:0]          mst_arvalid,
  input  logic [NM-1:0]          mst_awvalid,
  input  logic [NM*ADDRW-1:0]    mst_araddr,
  input  logic [NM*ADDRW-1:0]    mst_awaddr,
  input  logic [NM*IDW-1:0]      mst_arid,
  input  logic [NM*IDW-1:0]      mst_awid,
  input  logic [NM*PROTW-1:0]    mst_arprot,
  input  logic [NM*PROTW-1:0]    mst_awprot,
  input  logic [NM-1:0]          mst_wvalid,
  input  logic [NM*DATAW-1:0]    mst_wdata,
  input  logic [NM-1:0]          mst_rready,
  input  logic [NM-1:0]          mst_bready,
  output logic [NM-1:0]          mst_arready,
  output logic [NM-1:0]          mst_awready,
  output logic [NM-1:0]          mst_wready,
  output logic [NM-1:0]          mst_rvalid,
  output logic [NM-1:0]          mst_bvalid,
  output logic [DATAW-1:0]       mst_rdata,
  output logic [IDW-1:0]         mst_rid,
  output logic [IDW-1:0]         mst_bid,
  output logic [1:0]             mst_rresp,
  output logic                   apbif_arvalid,
  output logic                   apbif_awvalid,
  output logic [ADDRW-1:0]       apbif_araddr,
  output logic [ADDRW-1:0]       apbif_awaddr,
  output logic [IDW-1:0]         apbif_arid,
  output logic [IDW-1:0]         apbif_awid,
  output logic [PROTW-1:0]       apbif_arprot,
  output logic [PROTW-1:0]       apbif_awprot,
  output logic                   apbif_wvalid,
  output logic [DATAW-1:0]       apbif_wdata,
  output logic                   apbif_rready,
  input  logic                   apbif_arready,
  input  logic                   apbif_awready,
  input  logic                   apbif_wready,
  input  logic                   apbif_rvalid,
  input  logic [DATAW-1:0]       apbif_rdata,
  input  logic [IDW-1:0]         apbif_rid,
  input  logic [1:0]             apbif_rresp,
  input  logic                   apbif_idle,
  output logic                   apbarb_idle
);

  localparam int IW = $clog2(NM);

  if (NM < 2 || NM > NM_MAX) begin : g_bad_nm
    $error("aq_biu_apbarb: NM must be in 2..%0d", NM_MAX);
  end

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] bid_q, bid_d;

  logic [NM-1:0] req;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic [NM-1:0] gnt_oh;

  // Per-requester views of the flattened request buses.
  logic [ADDRW-1:0] araddr_a [NM];
  logic [ADDRW-1:0] awaddr_a [NM];
  logic [IDW-1:0]   arid_a   [NM];
  logic [IDW-1:0]   awid_a   [NM];
  logic [PROTW-1:0] arprot_a [NM];
  logic [PROTW-1:0] awprot_a [NM];
  logic [DATAW-1:0] wdata_a  [NM];

  for (genvar i = 0; i < NM; i++) begin : g_slot
    assign araddr_a[i] = mst_araddr[i*ADDRW +: ADDRW];
    assign awaddr_a[i] = mst_awaddr[i*ADDRW +: ADDRW];
    assign arid_a[i]   = mst_arid[i*IDW +: IDW];
    assign awid_a[i]   = mst_awid[i*IDW +: IDW];
    assign arprot_a[i] = mst_arprot[i*PROTW +: PROTW];
    assign awprot_a[i] = mst_awprot[i*PROTW +: PROTW];
    assign wdata_a[i]  = mst_wdata[i*DATAW +: DATAW];
  end

  assign req = mst_arvalid | mst_awvalid;

  aq_biu_rr_arb #(
    .NM (NM),
    .IW (IW)
  ) u_rr_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx),
    .gnt_oh  (gnt_oh)
  );

  // Only the index is needed here; the one-hot form is for integrators.
  logic unused_oh;
  assign unused_oh = ^gnt_oh;

  assign apbarb_idle = (state_q == ST_IDLE) && !(|req);

  // State, owner, round-robin pointer and latched write ID.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      bid_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      bid_q    <= bid_d;
    end
  end

  // Next state and owner-steered handshakes; non-owners always see zeros.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    bid_d         = bid_q;
    mst_arready   = '0;
    mst_awready   = '0;
    mst_wready    = '0;
    mst_rvalid    = '0;
    mst_bvalid    = '0;
    mst_rdata     = '0;
    mst_rid       = '0;
    mst_rresp     = RESP_OKAY;
    mst_bid       = bid_q;
    apbif_arvalid = 1'b0;
    apbif_awvalid = 1'b0;
    apbif_araddr  = '0;
    apbif_awaddr  = '0;
    apbif_arid    = '0;
    apbif_awid    = '0;
    apbif_arprot  = '0;
    apbif_awprot  = '0;
    apbif_wvalid  = 1'b0;
    apbif_wdata   = '0;
    apbif_rready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          owner_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == IW'(NM - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = mst_arvalid[gnt_idx] ? ST_AR : ST_AW;
        end
      end
      ST_AR: begin
        // Following the owner's valid makes a dropped request stall here.
        apbif_arvalid        = mst_arvalid[owner_q];
        apbif_araddr         = araddr_a[owner_q];
        apbif_arid           = arid_a[owner_q];
        apbif_arprot         = arprot_a[owner_q];
        mst_arready[owner_q] = apbif_arready;
        if (apbif_arvalid && apbif_arready) state_d = ST_RD;
      end
      ST_AW: begin
        apbif_awvalid        = mst_awvalid[owner_q];
        apbif_awaddr         = awaddr_a[owner_q];
        apbif_awid           = awid_a[owner_q];
        apbif_awprot         = awprot_a[owner_q];
        mst_awready[owner_q] = apbif_awready;
        if (apbif_awvalid && apbif_awready) begin
          bid_d   = awid_a[owner_q];
          state_d = ST_WD;
        end
      end
      ST_WD: begin
        apbif_wvalid        = mst_wvalid[owner_q];
        apbif_wdata         = wdata_a[owner_q];
        mst_wready[owner_q] = apbif_wready;
        if (apbif_wvalid && apbif_wready) state_d = ST_WB;
      end
      ST_RD: begin
        mst_rvalid[owner_q] = apbif_rvalid;
        apbif_rready        = mst_rready[owner_q];
        mst_rdata           = apbif_rdata;
        mst_rid             = apbif_rid;
        mst_rresp           = apbif_rresp;
        if (apbif_rvalid && apbif_rready) state_d = ST_IDLE;
      end
      ST_WB: begin
        if (apbif_idle) state_d = ST_BR;
      end
      ST_BR: begin
        mst_bvalid[owner_q] = 1'b1;
        if (mst_bready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A granted requester must hold its address valid until it is accepted.
  ar_hold_a: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    (state_q == ST_AR) |-> mst_arvalid[owner_q]);
  aw_hold_a: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    (state_q == ST_AW) |-> mst_awvalid[owner_q]);

endmodule
